// File: rtl/mult_booth_if.sv
// Operand/result bundle between the control unit and the Booth multiplier.
// The master issues start with its operands; the slave (the multiplier) returns status and product.
interface mult_booth_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, a, b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, a, b,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_booth.sv
// Sequential radix-2 Booth signed multiplier feeding the HI/LO registers for MULT.
// One Booth step per clock; the product appears in hi/lo WIDTH cycles after start is taken.
module mult_booth #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  mult_booth_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state, state_next;

  // One extra accumulator bit keeps ACC-M exact even for the most negative operands.
  logic signed [WIDTH:0]     m;
  logic signed [WIDTH:0]     acc;
  logic        [WIDTH-1:0]   q;
  logic                      q_m1;
  logic        [CW-1:0]      count;
  logic        [WIDTH-1:0]   hi_q;
  logic        [WIDTH-1:0]   lo_q;

  logic signed [WIDTH:0]     acc_sum;
  logic signed [2*WIDTH+1:0] step_vec;
  logic signed [WIDTH:0]     acc_shift;
  logic        [WIDTH-1:0]   q_shift;
  logic                      q_m1_shift;
  logic                      last_step;

  assign last_step = (count == CW'(WIDTH - 1));

  // Booth recoding of the current multiplier bit pair, then the arithmetic shift.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    acc_sum = acc;
    unique case ({q[0], q_m1})
      2'b01:   acc_sum = acc + m;
      2'b10:   acc_sum = acc - m;
      default: acc_sum = acc;
    endcase
    step_vec   = {acc_sum, q, q_m1};
    step_vec   = step_vec >>> 1;
    acc_shift  = step_vec[2*WIDTH+1 -: WIDTH+1];
    q_shift    = step_vec[WIDTH:1];
    q_m1_shift = step_vec[0];
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (bus.start) state_next = S_RUN;
      S_RUN:   if (last_step) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m     <= '0;
      acc   <= '0;
      q     <= '0;
      q_m1  <= 1'b0;
      count <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            m     <= {bus.a[WIDTH-1], bus.a};
            acc   <= '0;
            q     <= bus.b;
            q_m1  <= 1'b0;
            count <= '0;
          end
        end
        S_RUN: begin
          acc   <= acc_shift;
          q     <= q_shift;
          q_m1  <= q_m1_shift;
          count <= count + CW'(1);
          // hi/lo are only written here, so intermediate partial products never leak out.
          if (last_step) begin
            hi_q <= acc_shift[WIDTH-1:0];
            lo_q <= q_shift;
          end
        end
        default: ;
      endcase
    end
  end

  // Status is decoded purely from the state register: no input-to-output path.
  assign bus.busy = (state != S_IDLE);
  assign bus.done = (state == S_DONE);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mult_booth.sv
// Scoreboard bench for mult_booth: the driver queues hand-computed products,
// a monitor pops and compares one on every done pulse.
module tb_mult_booth;

  localparam int WIDTH = 32;

  logic clk;
  logic reset;

  mult_booth_if #(.WIDTH(WIDTH)) bus_if ();

  mult_booth #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] exp_q[$];
  logic [63:0] prev_prod = '0;

  int cyc           = 0;
  int last_done_cyc = -1;
  bit b2b_mode      = 1'b0;
  int done_seen     = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && bus_if.done) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        check("product", {bus_if.hi, bus_if.lo}, exp_q.pop_front());
      end
      if (b2b_mode && last_done_cyc >= 0)
        check("done_interval", 64'(cyc - last_done_cyc), 64'd34);
      last_done_cyc = cyc;
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // Single operation with latency/busy/stability checks; optional start intrusion during RUN.
  task automatic run_single(input logic [31:0] a, input logic [31:0] b,
                            input logic [63:0] exp, input bit intrude);
    int cycles;
    @(negedge clk);
    bus_if.a     = a;
    bus_if.b     = b;
    bus_if.start = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk);
    #1 bus_if.start = 1'b0;
    cycles = 0;
    while (!bus_if.done && cycles < 40) begin
      if (cycles == 0 || cycles == 20) begin
        check("busy_in_run", 64'(bus_if.busy), 64'd1);
        check("hold_in_run", {bus_if.hi, bus_if.lo}, prev_prod);
      end
      if (intrude && cycles == 10) begin
        bus_if.start = 1'b1;
        bus_if.a     = 32'd9;
        bus_if.b     = 32'd9;
      end
      @(posedge clk);
      #1 bus_if.start = 1'b0;
      cycles++;
    end
    check("latency", 64'(cycles), 64'd32);
    check("busy_in_done", 64'(bus_if.busy), 64'd1);
    @(posedge clk);
    #1;
    check("done_falls", 64'(bus_if.done), 64'd0);
    check("busy_falls", 64'(bus_if.busy), 64'd0);
    prev_prod = exp;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
  } vec_t;

  vec_t vecs[10] = '{
    '{32'd3,         32'd5,         64'h00000000_0000000F},
    '{32'hFFFFFFF9,  32'd6,         64'hFFFFFFFF_FFFFFFD6},
    '{32'd6,         32'hFFFFFFF9,  64'hFFFFFFFF_FFFFFFD6},
    '{32'h80000000,  32'h80000000,  64'h40000000_00000000},
    '{32'h80000000,  32'h7FFFFFFF,  64'hC0000000_80000000},
    '{32'h00010000,  32'h00010000,  64'h00000001_00000000},
    '{32'hFFFFFFFF,  32'h7FFFFFFF,  64'hFFFFFFFF_80000001},
    '{32'h12345678,  32'h00000100,  64'h00000012_34567800},
    '{32'd0,         32'hFFFFFFFB,  64'h00000000_00000000},
    '{32'h7FFFFFFF,  32'h7FFFFFFF,  64'h3FFFFFFF_00000001}
  };

  initial begin
    int seen_before;
    int wait_cnt;
    reset        = 1'b1;
    bus_if.start = 1'b0;
    bus_if.a     = '0;
    bus_if.b     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 64'(bus_if.busy), 64'd0);
    check("reset_done", 64'(bus_if.done), 64'd0);
    check("reset_hilo", {bus_if.hi, bus_if.lo}, 64'd0);
    @(negedge clk) reset = 1'b0;

    run_single(32'd3, 32'd5, 64'h00000000_0000000F, 1'b0);
    run_single(32'hFFFFFFF9, 32'd6, 64'hFFFFFFFF_FFFFFFD6, 1'b0);
    run_single(32'd6, 32'hFFFFFFF9, 64'hFFFFFFFF_FFFFFFD6, 1'b0);
    run_single(32'h80000000, 32'h80000000, 64'h40000000_00000000, 1'b0);
    run_single(32'h80000000, 32'h7FFFFFFF, 64'hC0000000_80000000, 1'b0);

    // Start during RUN is ignored: only one done, product 2*2.
    seen_before = done_seen;
    run_single(32'd2, 32'd2, 64'h00000000_00000004, 1'b1);
    repeat (40) @(posedge clk);
    check("no_second_done", 64'(done_seen - seen_before), 64'd1);
    run_single(32'd9, 32'd9, 64'h00000000_00000051, 1'b0);

    // Asynchronous reset mid-operation aborts without a done pulse.
    @(negedge clk);
    bus_if.a     = 32'h12345678;
    bus_if.b     = 32'h00000100;
    bus_if.start = 1'b1;
    @(posedge clk);
    #1 bus_if.start = 1'b0;
    repeat (15) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("abort_busy", 64'(bus_if.busy), 64'd0);
    check("abort_done", 64'(bus_if.done), 64'd0);
    check("abort_hilo", {bus_if.hi, bus_if.lo}, 64'd0);
    @(negedge clk) reset = 1'b0;
    seen_before = done_seen;
    repeat (40) @(posedge clk);
    check("abort_no_done", 64'(done_seen - seen_before), 64'd0);
    prev_prod = '0;
    run_single(32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001, 1'b0);

    // Back-to-back with start held high: a new done every 34 cycles.
    last_done_cyc = -1;
    b2b_mode      = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      wait_cnt = 0;
      while (bus_if.busy && wait_cnt < 50) begin
        @(posedge clk);
        #1;
        wait_cnt++;
      end
      if (wait_cnt >= 50) check("b2b_idle_timeout", 64'd1, 64'd0);
      bus_if.a     = vecs[i].a;
      bus_if.b     = vecs[i].b;
      bus_if.start = 1'b1;
      exp_q.push_back(vecs[i].p);
      @(posedge clk);
      #1;
    end
    bus_if.start = 1'b0;

    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 100) begin
      @(posedge clk);
      wait_cnt++;
    end
    @(posedge clk);
    b2b_mode = 1'b0;
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_booth.md
Name: mult_booth

Overview:
Sequential signed multiplier (radix-2 Booth) that feeds the HI/LO registers of the multicycle datapath for MULT.
- The control unit pulses start with the contents of registers A and B on the operand inputs.
- The block iterates for WIDTH cycles, then presents the 2*WIDTH-bit product split into hi/lo.
- The datapath write-back mux reads hi/lo for MFHI/MFLO.

Parameters:
WIDTH, 32, operand width; hi and lo are each WIDTH bits.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  request a multiply; sampled on rising edge, honoured only in IDLE.
a  input  WIDTH  multiplicand, signed two's complement; sampled with start.
b  input  WIDTH  multiplier, signed two's complement; sampled with start.
busy  output  1  high in RUN and DONE states.
done  output  1  one-cycle pulse, high during the DONE state.
hi  output  WIDTH  upper half of the last completed product.
lo  output  WIDTH  lower half of the last completed product.

Behaviour:
- One clock. Reset is asynchronous and active-high.
- Reset values:
  - state=IDLE; busy=0; done=0; hi=0; lo=0.
  - Internal accumulator, multiplier, Q-1 bit and counter all 0.
- States and transitions: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - On an edge with start=1: M<=sign-extend(a) to WIDTH+1 bits; Q<=b; ACC<=0 (WIDTH+1 bits); Q-1<=0; count<=0; state<=RUN.
  - a and b are not sampled again after this edge.
- RUN, one Booth step per edge:
  - {Q[0],Q-1}=01: ACC+M.
  - {Q[0],Q-1}=10: ACC-M.
  - 00 or 11: no add.
  - Then arithmetic right shift of {ACC,Q,Q-1} by one, replicating the ACC MSB.
  - count increments.
  - On the edge that performs step WIDTH (count==WIDTH-1 before the edge): hi<=ACC_final[WIDTH-1:0], lo<=Q_final, state<=DONE.
- DONE:
  - done=1 for exactly one cycle; busy=1.
  - Next edge goes to IDLE unconditionally.
- Width rule: ACC is WIDTH+1 bits, so that ACC-M never overflows, including a=b=-2^(WIDTH-1). The product is exact for all operand pairs. The product is {hi,lo}, signed 2*WIDTH bits.
- Latency: start sampled at edge E0. hi/lo are updated and done rises at edge E0+WIDTH (32 for the default). done falls at E0+WIDTH+1. start is accepted again from edge E0+WIDTH+2.
- hi/lo hold their value from completion until the next completion or reset. They do not change during RUN; intermediate results are never visible.
- start while busy (RUN or DONE) is ignored: no restart and no queueing.
- start held high continuously: a new operation starts on each IDLE edge, i.e. back-to-back with a one-cycle IDLE gap.
- Reset mid-operation: the operation is aborted immediately (asynchronously); all outputs return to their reset values; no done pulse is produced.
- Outputs are registered or decoded from the state register only; there are no combinational paths from inputs to outputs.

Test Plan:
- Small positives: reset, then a=3, b=5, start for 1 cycle -> done high exactly 32 cycles after the start edge, lo=0x0000000F, hi=0x00000000; busy high for 33 cycles.
- Mixed signs: a=-7 (0xFFFFFFF9), b=6 -> hi=0xFFFFFFFF, lo=0xFFFFFFD6. Repeat with a=6, b=-7 -> same result.
- Corner case: a=b=0x80000000 -> hi=0x40000000, lo=0x00000000. Also a=0x80000000, b=0x7FFFFFFF -> hi=0xC0000000, lo=0x80000000.
- Busy protection: start a=2, b=2; at cycle 10 assert start with a=9, b=9 -> result lo=4; no second done; hi/lo unchanged during RUN. Then re-start with a=9, b=9 -> lo=81.
- Reset mid-op: start a=0x12345678, b=0x100; assert reset at cycle 15 -> hi=lo=0, busy=done=0 immediately, no done afterwards. After release, start a=-1, b=-1 -> hi=0, lo=1.
- Random regression: 1000 random signed pairs with start back-to-back -> {hi,lo} equals the 64-bit signed reference product; a new done every 34 cycles.
